// File: rtl/image_pkg.sv
// Shared types and constants for the image_ddr_wr DDR3 frame writer.
package image_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CLOSE = 2'd2
  } state_t;

  localparam logic [2:0]  APP_CMD_WR      = 3'b000;
  localparam logic [27:0] FRAME_BASE0_DEF = 28'h000_0000;
  localparam logic [27:0] FRAME_BASE1_DEF = 28'h080_0000;

endpackage

// File: rtl/img_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module img_sync_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/image_ddr_wr.sv
// Ping-pong frame writer into DDR3 via the MIG native app interface.
// Define IMAGE_DDR_WR_STATS_EN to add the FRAME_BEATS per-frame beat count.
module image_ddr_wr
  import image_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int BURST_LEN  = 64,
  parameter int ADDR_W     = 28,
  parameter int ADDR_STEP  = 8,
  parameter int FIFO_DEPTH = 256,
  parameter logic [ADDR_W-1:0] FRAME_BASE0 = ADDR_W'(FRAME_BASE0_DEF),
  parameter logic [ADDR_W-1:0] FRAME_BASE1 = ADDR_W'(FRAME_BASE1_DEF),
  parameter int FLUSH_CYC  = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WR_EN,
  input  logic [DATA_W-1:0]   WR_DATA,
  input  logic                FRAME_END,
  input  logic                INIT_CALIB_COMPLETE,
  input  logic                app_rdy,
  input  logic                app_wdf_rdy,
  output logic                app_en,
  output logic [2:0]          app_cmd,
  output logic [ADDR_W-1:0]   app_addr,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                FRAME_DONE,
  output logic                RD_FRAME_SEL,
  output logic                OVERFLOW
`ifdef IMAGE_DDR_WR_STATS_EN
  ,
  output logic [31:0]         FRAME_BEATS
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = $clog2(FLUSH_CYC + 1);

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       w_count;
  logic [DATA_W-1:0]   w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_beat;
  logic                w_last;
  logic                w_burst_go;
  logic                w_part_go;
  logic                w_close_go;
  logic                w_enter_burst;
  logic                w_close;
  logic [CW-1:0]       r_tgt;
  logic [CW-1:0]       r_beat;
  logic [ADDR_W-1:0]   r_off;
  logic                r_wr_sel;
  logic                r_rd_sel;
  logic                r_ovf;
  logic                r_end_pend;
  logic                r_flush;
  logic [FW-1:0]       r_idle;

  img_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (WR_EN),
    .i_data  (WR_DATA),
    .i_pop   (w_beat),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_beat     = (r_state == BURST) & ~w_empty & app_rdy & app_wdf_rdy;
  assign w_last     = w_beat & (r_beat == r_tgt - 1'b1);
  assign w_burst_go = INIT_CALIB_COMPLETE & (w_count >= CW'(BURST_LEN));
  assign w_part_go  = INIT_CALIB_COMPLETE & r_flush & ~w_empty;
  assign w_close_go = r_flush & w_empty;

  assign w_enter_burst = (r_state == IDLE) & (w_next == BURST);
  assign w_close       = (r_state == IDLE) & (w_next == CLOSE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_burst_go || w_part_go) w_next = BURST;
        else if (w_close_go)         w_next = CLOSE;
      end
      BURST:   if (w_last) w_next = IDLE;
      CLOSE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    app_en       = w_beat;
    app_wdf_wren = w_beat;
    app_wdf_end  = w_beat;
    app_wdf_data = w_beat ? w_head : '0;
    FRAME_DONE   = (r_state == CLOSE);
  end

  assign app_cmd      = APP_CMD_WR;
  assign app_wdf_mask = '0;
  assign app_addr     = (r_wr_sel ? FRAME_BASE1 : FRAME_BASE0) + r_off;
  assign RD_FRAME_SEL = r_rd_sel;
  assign OVERFLOW     = r_ovf;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tgt    <= '0;
      r_beat   <= '0;
      r_off    <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_enter_burst) begin
        r_beat <= '0;
        r_tgt  <= w_burst_go ? CW'(BURST_LEN) : w_count;
      end else if (w_beat) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_beat) r_off <= r_off + ADDR_W'(ADDR_STEP);
      if (w_close) begin
        r_rd_sel <= r_wr_sel;
        r_wr_sel <= ~r_wr_sel;
        r_off    <= '0;
      end
      if (WR_EN && w_full) r_ovf <= 1'b1;
    end
  end

  // Frame closes only after FLUSH_CYC quiet cycles following FRAME_END
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_end_pend <= 1'b0;
      r_flush    <= 1'b0;
      r_idle     <= '0;
    end else begin
      if (FRAME_END && !r_flush) begin
        r_end_pend <= 1'b1;
        r_idle     <= '0;
      end else if (WR_EN) begin
        r_idle <= '0;
      end else if (r_end_pend) begin
        if (r_idle == FW'(FLUSH_CYC)) begin
          r_flush    <= 1'b1;
          r_end_pend <= 1'b0;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end
      if (w_close) r_flush <= 1'b0;
    end
  end

`ifdef IMAGE_DDR_WR_STATS_EN
  logic [31:0] r_total;
  logic [31:0] r_fbeats;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_total  <= '0;
      r_fbeats <= '0;
    end else if (w_close) begin
      r_fbeats <= r_total;
      r_total  <= '0;
    end else if (w_beat) begin
      r_total <= r_total + 32'd1;
    end
  end

  assign FRAME_BEATS = r_fbeats;
`endif

endmodule

// File: tb/tb_image_ddr_wr.sv
// Scoreboard bench for image_ddr_wr: frame table, overflow and reset cases.
module tb_image_ddr_wr;

  localparam int DW    = 128;
  localparam int AW    = 28;
  localparam int STEP  = 8;
  localparam int FLUSH = 16;
  localparam logic [AW-1:0] B0 = 28'h000_0000;
  localparam logic [AW-1:0] B1 = 28'h080_0000;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          WR_EN = 1'b0;
  logic [DW-1:0] WR_DATA = '0;
  logic          FRAME_END = 1'b0;
  logic          CALIB = 1'b0;
  logic          app_rdy = 1'b1;
  logic          app_wdf_rdy = 1'b1;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [DW-1:0] app_wdf_data;
  logic [15:0]   app_wdf_mask;
  logic          FRAME_DONE;
  logic          RD_FRAME_SEL;
  logic          OVERFLOW;
`ifdef IMAGE_DDR_WR_STATS_EN
  logic [31:0]   frame_beats;
`endif

  image_ddr_wr dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .WR_EN               (WR_EN),
    .WR_DATA             (WR_DATA),
    .FRAME_END           (FRAME_END),
    .INIT_CALIB_COMPLETE (CALIB),
    .app_rdy             (app_rdy),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .FRAME_DONE          (FRAME_DONE),
    .RD_FRAME_SEL        (RD_FRAME_SEL),
`ifdef IMAGE_DDR_WR_STATS_EN
    .FRAME_BEATS         (frame_beats),
`endif
    .OVERFLOW            (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int            beats;
    int            rdy_mode;
    logic          exp_sel;
    logic [AW-1:0] exp_last_off;
  } vec_t;

  beat_t         exp_q[$];
  beat_t         m_e;
  vec_t          vt[4];
  int            errors = 0;
  int            checks = 0;
  int            rdy_mode = 0;
  int            cyc = 0;
  int            beats_seen = 0;
  int            done_seen = 0;
  int            en_calib0 = 0;
  logic [AW-1:0] last_addr = '0;
  logic          tb_sel = 1'b0;
  logic [AW-1:0] tb_off = '0;

  function automatic logic [AW-1:0] base_of(input logic s);
    return s ? B1 : B0;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    cyc++;
    case (rdy_mode)
      1: begin
        app_rdy     = 1'b1;
        app_wdf_rdy = (cyc % 3 == 0);
      end
      default: begin
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
      end
    endcase
  end

  always begin
    @(negedge CLK);
    #2;
    if (!RST) begin
      if (app_en) begin
        chk("ready_ok", {127'd0, app_rdy & app_wdf_rdy}, 1);
        chk("wdf_wren", {127'd0, app_wdf_wren}, 1);
        chk("wdf_end", {127'd0, app_wdf_end}, 1);
        chk("app_cmd", {125'd0, app_cmd}, 0);
        chk("wdf_mask", {112'd0, app_wdf_mask}, 0);
        if (!CALIB) en_calib0++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr %0h expected none",
                   app_addr);
        end else begin
          m_e = exp_q.pop_front();
          chk("beat_addr", {100'd0, app_addr}, {100'd0, m_e.addr});
          chk("beat_data", app_wdf_data, m_e.data);
        end
        last_addr = app_addr;
        beats_seen++;
      end
      if (FRAME_DONE) done_seen++;
    end
  end

  task automatic push_one(input logic expect_it);
    @(negedge CLK);
    WR_EN   = 1'b1;
    WR_DATA = {$urandom, $urandom, $urandom, $urandom};
    if (expect_it) begin
      exp_q.push_back('{base_of(tb_sel) + tb_off, WR_DATA});
      tb_off = tb_off + AW'(STEP);
    end
  endtask

  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) push_one(1'b1);
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic end_frame(input logic exp_sel, input logic [AW-1:0] last_off);
    int q0;
    int lat;
    int d0;
    bit got;
    q0 = exp_q.size();
    d0 = done_seen;
    @(negedge CLK);
    FRAME_END = 1'b1;
    @(negedge CLK);
    FRAME_END = 1'b0;
    lat = 0;
    got = 1'b0;
    while (lat < 3000 && !got) begin
      @(negedge CLK);
      #3;
      lat++;
      if (FRAME_DONE) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: got no FRAME_DONE expected one");
    end else begin
      checks++;
      if (lat < FLUSH || lat > FLUSH + 8 + 4 * q0) begin
        errors++;
        $display("FAIL done_latency: got %0d expected %0d..%0d",
                 lat, FLUSH, FLUSH + 8 + 4 * q0);
      end
      chk("rd_frame_sel", {127'd0, RD_FRAME_SEL}, {127'd0, exp_sel});
    end
    chk("queue_drained", DW'(exp_q.size()), 0);
    chk("last_addr", {100'd0, last_addr},
        {100'd0, base_of(exp_sel) + last_off});
    repeat (5) @(negedge CLK);
    #3;
    chk("done_once", DW'(done_seen - d0), 1);
    tb_sel = ~tb_sel;
    tb_off = '0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_app_en"}, {127'd0, app_en}, 0);
    chk({p, "_wren"}, {127'd0, app_wdf_wren}, 0);
    chk({p, "_wdf_end"}, {127'd0, app_wdf_end}, 0);
    chk({p, "_addr"}, {100'd0, app_addr}, 0);
    chk({p, "_data"}, app_wdf_data, 0);
    chk({p, "_done"}, {127'd0, FRAME_DONE}, 0);
    chk({p, "_rdsel"}, {127'd0, RD_FRAME_SEL}, 0);
    chk({p, "_ovf"}, {127'd0, OVERFLOW}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int b0;
    vt[0] = '{256, 0, 1'b0, 28'd2040};
    vt[1] = '{256, 0, 1'b1, 28'd2040};
    vt[2] = '{100, 0, 1'b0, 28'd792};
    vt[3] = '{128, 1, 1'b1, 28'd1016};

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    #3;
    chk_zero("reset");
    @(negedge CLK);
    RST   = 1'b0;
    CALIB = 1'b1;
    repeat (3) @(negedge CLK);

    for (int k = 0; k < 4; k++) begin
      rdy_mode = vt[k].rdy_mode;
      send_beats(vt[k].beats);
      end_frame(vt[k].exp_sel, vt[k].exp_last_off);
      rdy_mode = 0;
    end

    CALIB     = 1'b0;
    en_calib0 = 0;
    send_beats(256);
    #3;
    chk("ovf_at_256", {127'd0, OVERFLOW}, 0);
    push_one(1'b0);
    @(negedge CLK);
    WR_EN = 1'b0;
    #3;
    chk("ovf_at_257", {127'd0, OVERFLOW}, 1);
    chk("no_cmd_uncal", DW'(en_calib0), 0);
    CALIB = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    end_frame(1'b0, 28'd2040);
    chk("ovf_sticky", {127'd0, OVERFLOW}, 1);

    b0 = beats_seen;
    for (int i = 0; i < 200; i++) begin
      push_one(1'b1);
      #3;
      if (beats_seen - b0 >= 30) break;
    end
    chk("beats_before_rst", DW'(beats_seen - b0), 30);
    #1;
    RST = 1'b1;
    #1;
    chk_zero("midrst");
    WR_EN = 1'b0;
    exp_q.delete();
    tb_sel = 1'b0;
    tb_off = '0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    send_beats(64);
    end_frame(1'b0, 28'd504);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/image_ddr_wr.md
Name: image_ddr_wr

Overview:
- Downstream stage of the PCIe image receive controller.
- Consumes its 128-bit burst stream (WR_EN/WR_DATA, 64-beat bursts) and its FRAME_END pulse.
- Writes frames linearly into DDR3 through the MIG native app interface, ping-ponging between two frame buffers.
- Reports which buffer holds the last complete frame, so a display/readback stage can read that buffer.

Parameters:
- DATA_W, 128, app_wdf_data / WR_DATA width.
- BURST_LEN, 64, beats per write burst; equals upstream burst size.
- ADDR_W, 28, app_addr width.
- ADDR_STEP, 8, app_addr increment per 128-bit beat (x16 DDR3, BL8).
- FIFO_DEPTH, 256, internal buffer depth in beats; power of 2, at least 2*BURST_LEN.
- FRAME_BASE0, 28'h000_0000, base address of buffer 0.
- FRAME_BASE1, 28'h080_0000, base address of buffer 1.
- FLUSH_CYC, 16, idle cycles after FRAME_END before the frame is closed.

Ports:
- CLK  in  1  single clock shared with the upstream stage and the MIG ui_clk.
- RST  in  1  asynchronous, active-high reset.
- WR_EN  in  1  upstream data valid; no backpressure.
- WR_DATA  in  DATA_W  upstream pixel word.
- FRAME_END  in  1  one-cycle pulse at the end of a frame.
- INIT_CALIB_COMPLETE  in  1  MIG calibration done.
- app_rdy  in  1  MIG command ready.
- app_wdf_rdy  in  1  MIG write-data ready.
- app_en  out  1  command valid.
- app_cmd  out  3  command; always 3'b000 (write).
- app_addr  out  ADDR_W  beat address.
- app_wdf_wren  out  1  write-data valid.
- app_wdf_end  out  1  last data of the command; always equals app_wdf_wren.
- app_wdf_data  out  DATA_W  write data.
- app_wdf_mask  out  DATA_W/8  byte mask; always 0.
- FRAME_DONE  out  1  one-cycle pulse when a frame is closed.
- RD_FRAME_SEL  out  1  buffer index of the last complete frame.
- OVERFLOW  out  1  sticky; a word was dropped.

Behaviour:
- Reset values: all outputs 0. Write buffer index wr_sel=0; address offset 0; FSM in IDLE; FIFO empty.
- Input buffering:
  - Every WR_EN beat is pushed into a FIFO_DEPTH x DATA_W synchronous FIFO.
  - WR_EN while the FIFO is full: beat dropped, OVERFLOW set to 1 until reset.
- FSM states and transitions:
  - IDLE -> BURST when INIT_CALIB_COMPLETE=1 and FIFO count >= BURST_LEN. Beat counter cleared on entry.
  - IDLE -> BURST when flush_req=1 and FIFO not empty (partial burst). Beat target = count sampled on entry.
  - BURST: per beat, app_en = app_wdf_wren = FIFO not empty & app_rdy & app_wdf_rdy (combinational).
    - A beat is transferred when app_en=1. That cycle: FIFO pops, app_addr advances by ADDR_STEP, beat counter increments.
    - app_addr = base(wr_sel) + offset. app_wdf_data = FIFO head (first-word-fall-through).
    - BURST -> IDLE after the target beat count is transferred.
  - CLOSE (entered from IDLE when flush_req=1 and FIFO empty):
    - RD_FRAME_SEL <= wr_sel; wr_sel toggles; offset cleared.
    - FRAME_DONE pulses for 1 cycle; flush_req cleared.
    - CLOSE -> IDLE next cycle.
- Flush logic:
  - FRAME_END sets end_pend and clears an idle counter. Any WR_EN also clears the counter.
  - When end_pend=1 and the counter reaches FLUSH_CYC: flush_req=1, end_pend=0.
  - FRAME_END while flush_req is already set is ignored (single close per frame).
- Offset: wraps modulo 2^ADDR_W. No bound checking against the other buffer.
- Latency: first app_en no earlier than 1 cycle after FIFO count reaches BURST_LEN.
- INIT_CALIB_COMPLETE=0: no commands issued; FIFO still accepts data and may overflow.
- Reset mid-burst: command and data stop immediately; the partial frame is lost.

Optional Feature:
- Macro IMAGE_DDR_WR_STATS_EN.
- Defined: adds output FRAME_BEATS [31:0], the number of beats written in the closed frame. Latched on the FRAME_DONE cycle; reset 0. The internal beat total clears after CLOSE.
- Undefined: port and counter are absent.

Decomposition:
- Package image_pkg holds: FSM state enum (IDLE, BURST, CLOSE), APP_CMD_WR=3'b000, default FRAME_BASE0/1 constants.
- One sub-module, img_sync_fifo: parameterised width and depth, first-word-fall-through, with count, full and empty outputs.

Test Plan:
- Calibrated, app_rdy=app_wdf_rdy=1; four 64-beat bursts of incrementing data; then FRAME_END:
  - Required: 256 writes at addr 0,8,...,2040 with data in order.
  - Required: FRAME_DONE pulses once, about 16 cycles after FRAME_END; RD_FRAME_SEL=0.
- Second identical frame: addresses start at 0x0800000; after FRAME_DONE, RD_FRAME_SEL=1.
- Frame of 100 beats (64+36): one 64-beat burst, then a 36-beat flush burst ending at offset 792; then FRAME_DONE.
- app_wdf_rdy toggling 1-of-3 cycles during a burst: app_en never asserted while either ready is low; no beat lost or duplicated.
- INIT_CALIB_COMPLETE=0 with 257 beats pushed: no app_en; OVERFLOW=1 after beat 257; 256 beats written after calibration rises.
- Assert RST mid-burst (beat 30): all outputs 0 immediately; the next frame restarts at FRAME_BASE0 with offset 0.
